dcache_controller: RTL and testbench

Sequencing FSM for the L1 data-cache datapath: it turns the datapath's hit/miss/dirty status into the mode, metadata and counter strobes that perform line write-back, line refill and CLFLUSH, and runs the word-by-word request/fulfil handshake with L2. It sits beside the datapath in the dcache top level, between the pipeline request port and the L2 port. It also keeps saturating performance counters.

---
 rtl/dcache_controller.sv | 176 +++++++++++++++++
 tb/tb_dcache_controller.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// L1 dcache sequencing FSM: hit/miss/dirty status -> write-back, refill and CLFLUSH strobes; saturating perf counters.
// Hits fulfil combinationally in the same cycle; L2 beats advance only on l2_req_fulfilled, with l2_req_valid held meanwhile.
package dcache_pkg;
  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    STORE   = 2'd1,
    CLFLUSH = 2'd2
  } memory_operation_e;
endpackage

module dcache_controller
  import dcache_pkg::*;
#(
  parameter int PERF_CNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pipe_req_valid,
  input  memory_operation_e         pipe_req_type,
  output logic                      pipe_req_fulfilled,
  input  logic                      hit,
  input  logic                      miss,
  input  logic                      valid_dirty_bit,
  input  logic                      clflush_requested,
  input  logic                      counter_done,
  output logic                      flush_mode,
  output logic                      load_mode,
  output logic                      clear_selected_dirty_bit,
  output logic                      clear_selected_valid_bit,
  output logic                      finish_new_line_install,
  output logic                      set_new_l2_block_address,
  output logic                      reset_counter,
  output logic                      decrement_counter,
  output logic                      l2_req_valid,
  output memory_operation_e         l2_req_type,
  input  logic                      l2_req_fulfilled,
  output logic                      busy,
  output logic [PERF_CNT_WIDTH-1:0] perf_hits,
  output logic [PERF_CNT_WIDTH-1:0] perf_misses,
  output logic [PERF_CNT_WIDTH-1:0] perf_writebacks
);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_WRITEBACK    = 2'd1,
    S_REFILL_SETUP = 2'd2,
    S_FETCH        = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic                      refilled_q, refilled_d;
  logic [PERF_CNT_WIDTH-1:0] hits_q, hits_d;
  logic [PERF_CNT_WIDTH-1:0] misses_q, misses_d;
  logic [PERF_CNT_WIDTH-1:0] wbs_q, wbs_d;
  logic                      hit_evt, miss_evt, wb_evt;

  always_comb begin
    state_d                  = state_q;
    pipe_req_fulfilled       = 1'b0;
    flush_mode               = 1'b0;
    load_mode                = 1'b0;
    clear_selected_dirty_bit = 1'b0;
    clear_selected_valid_bit = 1'b0;
    finish_new_line_install  = 1'b0;
    set_new_l2_block_address = 1'b0;
    reset_counter            = 1'b0;
    decrement_counter        = 1'b0;
    l2_req_valid             = 1'b0;
    l2_req_type              = LOAD;
    hit_evt                  = 1'b0;
    miss_evt                 = 1'b0;
    wb_evt                   = 1'b0;
    refilled_d               = refilled_q;

    case (state_q)
      S_IDLE: begin
        if (pipe_req_valid) begin
          if (pipe_req_type == CLFLUSH) begin
            if (miss) begin
              pipe_req_fulfilled = 1'b1;
            end else if (hit && !valid_dirty_bit) begin
              // Invalidate now; the re-presented request misses and fulfils next cycle.
              clear_selected_valid_bit = 1'b1;
            end else if (hit) begin
              set_new_l2_block_address = 1'b1;
              reset_counter            = 1'b1;
              state_d                  = S_WRITEBACK;
            end
          end else if (hit) begin
            pipe_req_fulfilled = 1'b1;
            hit_evt            = 1'b1;
          end else if (miss) begin
            set_new_l2_block_address = 1'b1;
            reset_counter            = 1'b1;
            miss_evt                 = 1'b1;
            state_d                  = valid_dirty_bit ? S_WRITEBACK : S_FETCH;
          end
        end
      end
      S_WRITEBACK: begin
        flush_mode   = 1'b1;
        l2_req_valid = 1'b1;
        l2_req_type  = STORE;
        if (l2_req_fulfilled) begin
          if (!counter_done) begin
            decrement_counter = 1'b1;
          end else begin
            clear_selected_dirty_bit = 1'b1;
            wb_evt                   = 1'b1;
            if (clflush_requested) begin
              clear_selected_valid_bit = 1'b1;
              state_d                  = S_IDLE;
            end else begin
              state_d = S_REFILL_SETUP;
            end
          end
        end
      end
      S_REFILL_SETUP: begin
        // Dirty bit is clear now, so the block address picks up the requested tag.
        set_new_l2_block_address = 1'b1;
        reset_counter            = 1'b1;
        state_d                  = S_FETCH;
      end
      S_FETCH: begin
        load_mode    = 1'b1;
        l2_req_valid = 1'b1;
        l2_req_type  = LOAD;
        if (l2_req_fulfilled) begin
          if (!counter_done) begin
            decrement_counter = 1'b1;
          end else begin
            finish_new_line_install = 1'b1;
            refilled_d              = 1'b1;
            state_d                 = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pipe_req_fulfilled) refilled_d = 1'b0;
  end

  // The hit that completes a refilled request was already counted as a miss.
  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    wbs_d    = wbs_q;
    if (hit_evt && !refilled_q && !(&hits_q)) hits_d = hits_q + PERF_CNT_WIDTH'(1);
    if (miss_evt && !(&misses_q))             misses_d = misses_q + PERF_CNT_WIDTH'(1);
    if (wb_evt && !(&wbs_q))                  wbs_d = wbs_q + PERF_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      refilled_q <= 1'b0;
      hits_q     <= '0;
      misses_q   <= '0;
      wbs_q      <= '0;
    end else begin
      state_q    <= state_d;
      refilled_q <= refilled_d;
      hits_q     <= hits_d;
      misses_q   <= misses_d;
      wbs_q      <= wbs_d;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign perf_hits       = hits_q;
  assign perf_misses     = misses_q;
  assign perf_writebacks = wbs_q;

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: a one-line datapath model plus a gap-programmable L2 responder around the DUT.
// Expected latencies, beat counts, counters and final line state come from per-request arithmetic.
module tb_dcache_controller;
  import dcache_pkg::*;

  localparam int W    = 4;
  localparam int MAXC = (1 << W) - 1;
  localparam int TMO  = 400;

  logic              clk = 1'b0;
  logic              reset;
  logic              pipe_req_valid;
  memory_operation_e pipe_req_type;
  logic              pipe_req_fulfilled;
  logic              hit, miss, valid_dirty_bit, clflush_requested, counter_done;
  logic              flush_mode, load_mode;
  logic              clear_selected_dirty_bit, clear_selected_valid_bit, finish_new_line_install;
  logic              set_new_l2_block_address, reset_counter, decrement_counter;
  logic              l2_req_valid;
  memory_operation_e l2_req_type;
  logic              l2_req_fulfilled;
  logic              busy;
  logic [W-1:0]      perf_hits, perf_misses, perf_writebacks;

  dcache_controller #(.PERF_CNT_WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .pipe_req_valid(pipe_req_valid), .pipe_req_type(pipe_req_type),
    .pipe_req_fulfilled(pipe_req_fulfilled),
    .hit(hit), .miss(miss), .valid_dirty_bit(valid_dirty_bit),
    .clflush_requested(clflush_requested), .counter_done(counter_done),
    .flush_mode(flush_mode), .load_mode(load_mode),
    .clear_selected_dirty_bit(clear_selected_dirty_bit),
    .clear_selected_valid_bit(clear_selected_valid_bit),
    .finish_new_line_install(finish_new_line_install),
    .set_new_l2_block_address(set_new_l2_block_address),
    .reset_counter(reset_counter), .decrement_counter(decrement_counter),
    .l2_req_valid(l2_req_valid), .l2_req_type(l2_req_type),
    .l2_req_fulfilled(l2_req_fulfilled), .busy(busy),
    .perf_hits(perf_hits), .perf_misses(perf_misses), .perf_writebacks(perf_writebacks)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Datapath model: a single selected line plus the beat counter.
  logic       dp_valid, dp_dirty;
  logic [3:0] dp_tag;
  int         dp_cnt;
  int         exp_hits, exp_misses, exp_wbs;
  int         last_fin_cyc;

  function automatic int sat(input int v);
    return (v < MAXC) ? v + 1 : MAXC;
  endfunction

  task automatic set_line(input logic v, input logic d, input logic [3:0] tg);
    dp_valid = v; dp_dirty = d; dp_tag = tg;
  endtask

  task automatic run_req(input memory_operation_e t, input logic [3:0] tg, input int mingap,
                         input int maxgap, input int abort_fe, output int lat);
    int wb_g[8], fe_g[8];
    int wsum, fsum, e_lat, e_wb, e_fe, e_dec;
    int cyc, wc, wb_i, fe_i, nwb, nfe, ndec, busy_err;
    logic pre_hit, pre_vd, done, e_valid, e_dirty;
    wsum = 0; fsum = 0;
    for (int i = 0; i < 8; i++) begin
      wb_g[i] = $urandom_range(maxgap, mingap); wsum += wb_g[i] + 1;
      fe_g[i] = $urandom_range(maxgap, mingap); fsum += fe_g[i] + 1;
    end
    pre_hit = dp_valid && (dp_tag == tg);
    pre_vd  = dp_valid && dp_dirty;
    e_wb = 0; e_fe = 0;
    e_valid = dp_valid; e_dirty = dp_dirty;
    if (t != CLFLUSH) begin
      if (pre_hit) begin
        e_lat = 0; exp_hits = sat(exp_hits);
      end else begin
        exp_misses = sat(exp_misses);
        e_fe = 8;
        if (pre_vd) begin e_wb = 8; e_lat = 2 + wsum + fsum; exp_wbs = sat(exp_wbs); end
        else e_lat = 1 + fsum;
      end
      e_valid = 1'b1;
      e_dirty = (t == STORE) || (pre_hit && dp_dirty);
    end else if (!pre_hit) begin
      e_lat = 0;
    end else begin
      if (pre_vd) begin e_wb = 8; e_lat = 1 + wsum; exp_wbs = sat(exp_wbs); end
      else e_lat = 1;
      e_valid = 1'b0; e_dirty = 1'b0;
    end
    e_dec = 7 * ((e_wb + e_fe) / 8);

    cyc = 0; done = 1'b0; wc = -1; wb_i = 0; fe_i = 0;
    nwb = 0; nfe = 0; ndec = 0; busy_err = 0; lat = -1; last_fin_cyc = -1;
    while (!done && cyc < TMO) begin
      @(negedge clk);
      pipe_req_valid    = 1'b1;
      pipe_req_type     = t;
      clflush_requested = (t == CLFLUSH);
      hit               = dp_valid && (dp_tag == tg);
      miss              = !(dp_valid && (dp_tag == tg));
      valid_dirty_bit   = dp_valid && dp_dirty;
      counter_done      = (dp_cnt == 0);
      #1;
      if (l2_req_valid) begin
        if (wc < 0)
          wc = (l2_req_type == STORE) ? ((wb_i < 8) ? wb_g[wb_i] : 0) : ((fe_i < 8) ? fe_g[fe_i] : 0);
        if (wc == 0) begin l2_req_fulfilled = 1'b1; wc = -1; end
        else begin l2_req_fulfilled = 1'b0; wc--; end
      end else begin
        l2_req_fulfilled = 1'($urandom_range(1, 0));
      end
      #1;
      if (l2_req_valid && l2_req_fulfilled) begin
        if (l2_req_type == STORE) begin nwb++; wb_i++; end
        else begin nfe++; fe_i++; end
      end
      if (decrement_counter) ndec++;
      if (busy !== ((cyc > 0) && (cyc < e_lat))) busy_err++;
      if (reset_counter) dp_cnt = 7;
      else if (decrement_counter && dp_cnt > 0) dp_cnt--;
      if (clear_selected_dirty_bit) dp_dirty = 1'b0;
      if (clear_selected_valid_bit) dp_valid = 1'b0;
      if (finish_new_line_install) begin
        dp_valid = 1'b1; dp_tag = tg; dp_dirty = 1'b0; last_fin_cyc = cyc;
      end
      if (pipe_req_fulfilled) begin
        done = 1'b1; lat = cyc;
        if (t == STORE) dp_dirty = 1'b1;
      end
      if (abort_fe > 0 && nfe == abort_fe) done = 1'b1;
      cyc++;
    end
    if (abort_fe > 0) return;

    n_checks++;
    if (lat !== e_lat) begin
      n_fail++; $display("FAIL latency %s tag %0d: got %0d expected %0d", t.name(), tg, lat, e_lat);
    end
    n_checks++;
    if (nwb !== e_wb || nfe !== e_fe) begin
      n_fail++; $display("FAIL l2_beats: got wb=%0d fe=%0d expected wb=%0d fe=%0d", nwb, nfe, e_wb, e_fe);
    end
    n_checks++;
    if (ndec !== e_dec) begin
      n_fail++; $display("FAIL decrements: got %0d expected %0d", ndec, e_dec);
    end
    n_checks++;
    if (busy_err !== 0) begin
      n_fail++; $display("FAIL busy: %0d cycles wrong, expected 0", busy_err);
    end
    n_checks++;
    if (dp_valid !== e_valid || dp_dirty !== e_dirty || (e_valid && t != CLFLUSH && dp_tag !== tg)) begin
      n_fail++;
      $display("FAIL line_state: got v=%0b d=%0b tag=%0d expected v=%0b d=%0b tag=%0d",
               dp_valid, dp_dirty, dp_tag, e_valid, e_dirty, tg);
    end
    @(posedge clk); #1;
    pipe_req_valid = 1'b0; l2_req_fulfilled = 1'b0;
    n_checks++;
    if (perf_hits !== W'(exp_hits) || perf_misses !== W'(exp_misses) || perf_writebacks !== W'(exp_wbs)) begin
      n_fail++;
      $display("FAIL perf: got h=%0d m=%0d wb=%0d expected h=%0d m=%0d wb=%0d",
               perf_hits, perf_misses, perf_writebacks, exp_hits, exp_misses, exp_wbs);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1; pipe_req_valid = 1'b0; pipe_req_type = LOAD; l2_req_fulfilled = 1'b0;
    hit = 1'b0; miss = 1'b0; valid_dirty_bit = 1'b0; clflush_requested = 1'b0; counter_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_hits = 0; exp_misses = 0; exp_wbs = 0; dp_cnt = 0;
    set_line(1'b0, 1'b0, 4'd0);
    n_checks++;
    if (busy !== 1'b0 || l2_req_valid !== 1'b0 || l2_req_type !== LOAD || pipe_req_fulfilled !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: busy=%0b l2v=%0b type=%0d ful=%0b expected 0 0 0 0",
                         busy, l2_req_valid, l2_req_type, pipe_req_fulfilled);
    end
    n_checks++;
    if ({flush_mode, load_mode, clear_selected_dirty_bit, clear_selected_valid_bit, finish_new_line_install,
         set_new_l2_block_address, reset_counter, decrement_counter} !== 8'h00) begin
      n_fail++; $display("FAIL reset_strobes: some strobe set, expected all 0");
    end
    n_checks++;
    if (perf_hits !== '0 || perf_misses !== '0 || perf_writebacks !== '0) begin
      n_fail++; $display("FAIL reset_perf: got %0d %0d %0d expected 0 0 0", perf_hits, perf_misses, perf_writebacks);
    end
  endtask

  task automatic test_load_hit;
    int lat;
    set_line(1'b1, 1'b0, 4'd5);
    run_req(LOAD, 4'd5, 0, 0, 0, lat);
    n_checks++;
    if (perf_hits !== W'(1)) begin
      n_fail++; $display("FAIL load_hit_perf: got %0d expected 1", perf_hits);
    end
  endtask

  task automatic test_clean_miss;
    int lat;
    set_line(1'b1, 1'b0, 4'd1);
    run_req(LOAD, 4'd2, 0, 0, 0, lat);
    n_checks++;
    if (last_fin_cyc !== 8 || lat !== 9) begin
      n_fail++; $display("FAIL clean_miss_timing: finish %0d fulfil %0d expected 8 9", last_fin_cyc, lat);
    end
  endtask

  task automatic test_dirty_miss;
    int lat;
    set_line(1'b1, 1'b1, 4'd3);
    run_req(STORE, 4'd4, 2, 2, 0, lat);
    n_checks++;
    if (lat !== 50) begin
      n_fail++; $display("FAIL dirty_miss_slow: fulfil %0d expected 50", lat);
    end
  endtask

  task automatic test_clflush;
    int lat;
    set_line(1'b1, 1'b0, 4'd6);
    run_req(CLFLUSH, 4'd6, 0, 0, 0, lat);
    set_line(1'b1, 1'b1, 4'd7);
    run_req(CLFLUSH, 4'd7, 0, 0, 0, lat);
    n_checks++;
    if (lat !== 9) begin
      n_fail++; $display("FAIL clflush_dirty_timing: fulfil %0d expected 9", lat);
    end
    set_line(1'b1, 1'b1, 4'd1);
    run_req(CLFLUSH, 4'd2, 0, 0, 0, lat);
  endtask

  task automatic test_random;
    int lat;
    memory_operation_e t;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(2, 0))
        0:       t = LOAD;
        1:       t = STORE;
        default: t = CLFLUSH;
      endcase
      run_req(t, 4'($urandom_range(3, 0)), 0, $urandom_range(3, 0), 0, lat);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    test_reset;
    set_line(1'b1, 1'b0, 4'd8);
    run_req(LOAD, 4'd9, 0, 0, 4, lat);
    reset = 1'b1; pipe_req_valid = 1'b0; l2_req_fulfilled = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || l2_req_valid !== 1'b0 || perf_misses !== '0 || finish_new_line_install !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_fetch: busy=%0b l2v=%0b misses=%0d fin=%0b expected 0 0 0 0",
                         busy, l2_req_valid, perf_misses, finish_new_line_install);
    end
    reset = 1'b0;
    exp_hits = 0; exp_misses = 0; exp_wbs = 0;
  endtask

  task automatic test_saturation;
    int lat;
    test_reset;
    for (int i = 0; i < 17; i++) run_req(LOAD, 4'(i), 0, 0, 0, lat);
    n_checks++;
    if (perf_misses !== W'(MAXC)) begin
      n_fail++; $display("FAIL miss_saturation: got %0d expected %0d", perf_misses, MAXC);
    end
  endtask

  initial begin
    test_reset;
    test_load_hit;
    test_clean_miss;
    test_dirty_miss;
    test_clflush;
    test_random;
    test_reset_mid;
    test_saturation;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
